load_ext_pipe: RTL and testbench

- Two-stage pipelined load-data aligner and extender for the MEM→WB path of the pipelined CPU.
- Takes the raw memory word, the low address bits, the access size and a signed/unsigned flag.
- Selects the addressed byte, half or word lane and zero- or sign-extends it to the full data width.
- Carries a destination tag alongside the data, uses valid/ready handshakes on both sides, and flags misaligned accesses.

---
 rtl/load_ext_pipe_if.sv | 34 +++
 rtl/load_ext_pipe.sv | 111 +++++++++++
 tb/tb_load_ext_pipe.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_ext_pipe_if.sv
// Load-extend pipeline bus: upstream operation fields with valid/ready,
// downstream result fields with valid/ready.
interface load_ext_pipe_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
);
    localparam int OFF_W = $clog2(DATA_W / 8);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [OFF_W-1:0]  in_off;
    logic [1:0]        in_size;
    logic              in_sign;
    logic [TAG_W-1:0]  in_tag;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_misalign;

    // Producer of operations / consumer of results (e.g. the MEM stage and WB stage).
    modport master (
        output in_valid, in_data, in_off, in_size, in_sign, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_misalign
    );

    // The aligner/extender itself.
    modport slave (
        input  in_valid, in_data, in_off, in_size, in_sign, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_misalign
    );
endinterface

// File: rtl/load_ext_pipe.sv
// Two-stage load-data aligner/extender for the MEM->WB path.
// Stage 1 shifts the addressed lane down to bit 0 and flags misalignment;
// stage 2 zero/sign-extends the lane and holds the result for the consumer.
module load_ext_pipe #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    load_ext_pipe_if.slave bus
);
    localparam int OFF_W = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_e;

    // Stage 1 registers
    logic              s1_valid;
    logic [DATA_W-1:0] s1_lane;
    size_e             s1_size;
    logic              s1_sign;
    logic [TAG_W-1:0]  s1_tag;
    logic              s1_mis;

    logic              s1_adv;
    logic              accept;
    logic              in_mis;
    logic [6:0]        shamt;
    logic [DATA_W-1:0] ext;

    // Stage 1 moves forward when stage 2 is empty or being drained this cycle.
    assign s1_adv       = s1_valid & (!bus.out_valid | bus.out_ready);
    assign bus.in_ready = !flush & (!s1_valid | s1_adv);
    assign accept       = bus.in_valid & bus.in_ready;

    // Flag accesses whose offset is not a multiple of their size, and dword on a 32-bit path.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        in_mis = 1'b0;
        case (size_e'(bus.in_size))
            SZ_BYTE:  in_mis = 1'b0;
            SZ_HALF:  in_mis = bus.in_off[0];
            SZ_WORD:  in_mis = (bus.in_off[1:0] != 2'b00);
            SZ_DWORD: in_mis = (DATA_W == 32) ? 1'b1 : (bus.in_off != '0);
        endcase
    end

    // Stage 1 occupancy; flush and reset empty it.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update together.
        if (rst || flush)
            s1_valid <= 1'b0;
        else if (accept)
            s1_valid <= 1'b1;
        else if (s1_adv)
            s1_valid <= 1'b0;
    end

    // Stage 1 payload: addressed lane shifted down to bit 0, plus its attributes.
    always_ff @(posedge clk) begin
        // NOTE: payload registers have no reset; they are only observed while s1_valid is set.
        if (accept) begin
            s1_lane <= bus.in_data >> {bus.in_off, 3'b000};
            s1_size <= size_e'(bus.in_size);
            s1_sign <= bus.in_sign;
            s1_tag  <= bus.in_tag;
            s1_mis  <= in_mis;
        end
    end

    // Extend the lane: shift it to the top and back, arithmetic for sign, logical for zero.
    // Full-width accesses give shamt = 0 and pass through; misaligned ones yield zero.
    always_comb begin
        shamt = 7'(DATA_W) - (7'd8 << s1_size);
        ext   = '0;
        if (!s1_mis) begin
            if (s1_sign)
                ext = $signed(s1_lane << shamt) >>> shamt;
            else
                ext = (s1_lane << shamt) >> shamt;
        end
    end

    // Stage 2 occupancy: filled from stage 1, emptied by a consumer transfer, cleared by flush.
    always_ff @(posedge clk) begin
        if (rst || flush)
            bus.out_valid <= 1'b0;
        else if (s1_adv)
            bus.out_valid <= 1'b1;
        else if (bus.out_ready)
            bus.out_valid <= 1'b0;
    end

    // Stage 2 result registers; they only change when a new result moves in, so stalls hold them.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_data     <= '0;
            bus.out_tag      <= '0;
            bus.out_misalign <= 1'b0;
        end else if (s1_adv && !flush) begin
            bus.out_data     <= ext;
            bus.out_tag      <= s1_tag;
            bus.out_misalign <= s1_mis;
        end
    end
endmodule

// File: tb/tb_load_ext_pipe.sv
// Scoreboard bench for load_ext_pipe: a 32-bit and a 64-bit instance.
// Drivers push expected results at acceptance; per-instance monitors pop and
// compare whenever a result transfers.
module tb_load_ext_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    load_ext_pipe_if #(.DATA_W(32), .TAG_W(5)) b32 ();
    load_ext_pipe_if #(.DATA_W(64), .TAG_W(5)) b64 ();

    load_ext_pipe #(.DATA_W(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .bus(b32.slave)
    );
    load_ext_pipe #(.DATA_W(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .bus(b64.slave)
    );

    typedef struct {
        logic [63:0] data;
        logic [4:0]  tag;
        logic        mis;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor for the 32-bit instance.
    always @(negedge clk) begin : mon32
        exp_t e;
        if (!rst && !flush && b32.out_valid && b32.out_ready) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out32: got tag %0d, expected no output", b32.out_tag);
            end else begin
                e = q32.pop_front();
                check($sformatf("data32_tag%0d", e.tag), 64'(b32.out_data), e.data);
                check($sformatf("tag32_tag%0d", e.tag), 64'(b32.out_tag), 64'(e.tag));
                check($sformatf("mis32_tag%0d", e.tag), 64'(b32.out_misalign), 64'(e.mis));
                if (e.lat)
                    check($sformatf("lat32_tag%0d", e.tag), 64'(cyc - e.acc), 64'd2);
            end
        end
    end

    // Monitor for the 64-bit instance.
    always @(negedge clk) begin : mon64
        exp_t e;
        if (!rst && !flush && b64.out_valid && b64.out_ready) begin
            if (q64.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out64: got tag %0d, expected no output", b64.out_tag);
            end else begin
                e = q64.pop_front();
                check($sformatf("data64_tag%0d", e.tag), b64.out_data, e.data);
                check($sformatf("tag64_tag%0d", e.tag), 64'(b64.out_tag), 64'(e.tag));
                check($sformatf("mis64_tag%0d", e.tag), 64'(b64.out_misalign), 64'(e.mis));
                if (e.lat)
                    check($sformatf("lat64_tag%0d", e.tag), 64'(cyc - e.acc), 64'd2);
            end
        end
    end

    // Present one operation (called at posedge+1), hold it until accepted, return at posedge+1.
    task automatic send(input bit wide, input logic [63:0] data, input int off,
                        input logic [1:0] size, input bit sign, input logic [4:0] tag,
                        input logic [63:0] exp_data, input bit exp_mis, input bit lat);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        e.data = exp_data;
        e.tag  = tag;
        e.mis  = exp_mis;
        e.lat  = lat;
        e.acc  = 0;
        if (wide) begin
            b64.in_valid = 1'b1;
            b64.in_data  = data;
            b64.in_off   = 3'(off);
            b64.in_size  = size;
            b64.in_sign  = sign;
            b64.in_tag   = tag;
        end else begin
            b32.in_valid = 1'b1;
            b32.in_data  = data[31:0];
            b32.in_off   = 2'(off);
            b32.in_size  = size;
            b32.in_sign  = sign;
            b32.in_tag   = tag;
        end
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (wide ? b64.in_ready : b32.in_ready) begin
                ok = 1'b1;
                e.acc = cyc;
                if (wide) q64.push_back(e);
                else      q32.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        b32.in_valid = 1'b0;
        b64.in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: tag %0d not accepted, expected acceptance", tag);
        end
    endtask

    // Wait (bounded) until both scoreboards are empty and no result is pending.
    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (q32.size() == 0 && q64.size() == 0 && !b32.out_valid && !b64.out_valid)
                done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d+%0d pending, expected 0", q32.size(), q64.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit reached");
    end

    initial begin
        b32.in_valid = 1'b0; b32.in_data = '0; b32.in_off = '0; b32.in_size = '0;
        b32.in_sign = 1'b0;  b32.in_tag = '0;  b32.out_ready = 1'b1;
        b64.in_valid = 1'b0; b64.in_data = '0; b64.in_off = '0; b64.in_size = '0;
        b64.in_sign = 1'b0;  b64.in_tag = '0;  b64.out_ready = 1'b1;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 64'(b32.out_valid), 64'd0);
        check("reset_out_data", 64'(b32.out_data), 64'd0);
        check("reset_out_tag", 64'(b32.out_tag), 64'd0);
        check("reset_out_misalign", 64'(b32.out_misalign), 64'd0);
        check("reset_in_ready", 64'(b32.in_ready), 64'd1);
        check("reset_out_valid64", 64'(b64.out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Directed alignment/extension vectors, 32-bit path
        send(0, 64'h12345680, 0, 2'b00, 1, 5'd1,  64'hFFFF_FF80, 0, 1);
        send(0, 64'h12345680, 3, 2'b00, 0, 5'd2,  64'h0000_0012, 0, 1);
        send(0, 64'h12345680, 1, 2'b00, 1, 5'd3,  64'h0000_0056, 0, 1);
        send(0, 64'h80017FFF, 2, 2'b01, 1, 5'd4,  64'hFFFF_8001, 0, 1);
        send(0, 64'h80017FFF, 0, 2'b01, 1, 5'd5,  64'h0000_7FFF, 0, 1);
        send(0, 64'h80017FFF, 2, 2'b01, 0, 5'd6,  64'h0000_8001, 0, 1);
        send(0, 64'h80017FFF, 0, 2'b10, 1, 5'd10, 64'h8001_7FFF, 0, 1);
        // Misaligned / illegal
        send(0, 64'h80017FFF, 1, 2'b01, 1, 5'd7,  64'h0, 1, 1);
        send(0, 64'h80017FFF, 2, 2'b10, 0, 5'd8,  64'h0, 1, 1);
        send(0, 64'h80017FFF, 0, 2'b11, 0, 5'd9,  64'h0, 1, 1);
        wait_idle();

        // Backpressure: five back-to-back ops, consumer stalls 4 cycles once tag 1 shows
        fork
            begin
                for (int t = 1; t <= 5; t++)
                    send(0, 64'(t * 17), 0, 2'b00, 0, 5'(t), 64'(t * 17), 0, 0);
            end
            begin : ctrl
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(posedge clk);
                    #1;
                    if (b32.out_valid) begin
                        b32.out_ready = 1'b0;
                        seen = 1'b1;
                    end
                end
                if (!seen) begin
                    checks++;
                    errors++;
                    $display("FAIL bp_first_out: got no output, expected tag 1");
                end else begin
                    for (int k = 0; k < 4; k++) begin
                        @(negedge clk);
                        check("stall_out_valid", 64'(b32.out_valid), 64'd1);
                        check("stall_out_tag", 64'(b32.out_tag), 64'd1);
                        check("stall_out_data", 64'(b32.out_data), 64'd17);
                        check("stall_in_ready", 64'(b32.in_ready), 64'd0);
                    end
                    @(posedge clk);
                    #1;
                    b32.out_ready = 1'b1;
                    for (int k = 0; k < 5; k++) begin
                        @(negedge clk);
                        check("drain_no_gap", 64'(b32.out_valid), 64'd1);
                    end
                end
            end
        join
        wait_idle();

        // Flush with two ops in flight and a new op offered in the flush cycle
        send(0, 64'hA5, 0, 2'b00, 0, 5'd20, 64'hA5, 0, 0);
        send(0, 64'hA6, 0, 2'b00, 0, 5'd21, 64'hA6, 0, 0);
        check("flush_pre_out_valid", 64'(b32.out_valid), 64'd1);
        flush = 1'b1;
        b32.in_valid = 1'b1;
        b32.in_data  = 32'hC3;
        b32.in_off   = 2'd0;
        b32.in_size  = 2'b00;
        b32.in_sign  = 1'b0;
        b32.in_tag   = 5'd22;
        @(negedge clk);
        check("flush_in_ready", 64'(b32.in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        b32.in_valid = 1'b0;
        q32.delete();
        @(negedge clk);
        check("flush_out_valid", 64'(b32.out_valid), 64'd0);
        @(negedge clk);
        check("flush_no_late_out", 64'(b32.out_valid), 64'd0);
        @(posedge clk);
        #1;
        send(0, 64'hF0, 0, 2'b00, 1, 5'd23, 64'hFFFF_FFF0, 0, 1);
        wait_idle();

        // Reset while a result is waiting
        b32.out_ready = 1'b0;
        send(0, 64'h12345680, 0, 2'b00, 1, 5'd24, 64'hFFFF_FF80, 0, 0);
        send(0, 64'h12345680, 3, 2'b00, 0, 5'd25, 64'h12, 0, 0);
        check("rst_pre_out_valid", 64'(b32.out_valid), 64'd1);
        rst = 1'b1;
        q32.delete();
        @(posedge clk);
        #1;
        check("rst_mid_out_valid", 64'(b32.out_valid), 64'd0);
        check("rst_mid_out_data", 64'(b32.out_data), 64'd0);
        check("rst_mid_out_tag", 64'(b32.out_tag), 64'd0);
        rst = 1'b0;
        b32.out_ready = 1'b1;
        repeat (8) @(negedge clk);
        check("rst_quiet_after", 64'(b32.out_valid), 64'd0);
        @(posedge clk);
        #1;

        // 64-bit instance
        send(1, 64'h8123_4567_89AB_CDEF, 0, 2'b11, 1, 5'd26, 64'h8123_4567_89AB_CDEF, 0, 1);
        send(1, 64'h8000_0000_1234_5678, 4, 2'b10, 1, 5'd27, 64'hFFFF_FFFF_8000_0000, 0, 1);
        send(1, 64'h8000_0000_1234_5678, 4, 2'b10, 0, 5'd28, 64'h0000_0000_8000_0000, 0, 1);
        send(1, 64'h8000_0000_1234_5678, 0, 2'b01, 1, 5'd29, 64'h0000_0000_0000_5678, 0, 1);
        send(1, 64'h8000_0000_1234_5678, 4, 2'b11, 0, 5'd30, 64'h0, 1, 1);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
